systolic_seq: RTL and testbench

Frame sequencer for the `systolic` datapath. The datapath has an 8-bit sample input, a 16-bit sum output, and no enable or valid.
- Accepts samples from an upstream valid/ready stream and drives exactly N_TAPS sample cycles into the array.
- Then drives zeros for LATENCY flush cycles, captures `sum_out`, and presents the result on a valid/ready output port.
- Sits between the UART receive path and the UART transmit path.

---
 rtl/systolic_seq_if.sv | 38 +++
 rtl/systolic_seq.sv | 142 ++++++++++++++
 tb/tb_systolic_seq.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_seq_if.sv
// -----------------------------------------------------------------------------
// systolic_seq_if
//   Stream bundle around the systolic frame sequencer: the upstream sample
//   stream (in_*) and the downstream result stream (out_*).
//
//   Signals:
//     in_data   [DATA_W]  upstream sample
//     in_valid            upstream sample valid
//     in_ready            sequencer accepts in_data this cycle
//     out_data  [SUM_W]   captured frame result
//     out_valid           result valid
//     out_ready           downstream accepts the result
//
//   Modports:
//     slave   - the sequencer's view (consumes samples, produces results)
//     master  - the surrounding environment's view
// -----------------------------------------------------------------------------
interface systolic_seq_if #(
    parameter int DATA_W = 8,
    parameter int SUM_W  = 16
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [SUM_W-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );
endinterface

// File: rtl/systolic_seq.sv
// -----------------------------------------------------------------------------
// systolic_seq
//   Frame sequencer for the systolic datapath (8-bit sample in, 16-bit sum
//   out, no enable/valid). It pulls N_TAPS samples from the upstream stream
//   and feeds them to the array one per cycle, feeds zeros for LATENCY flush
//   cycles, captures the array sum and offers it on the result stream.
//
//   Ports:
//     clk          single clock, rising edge
//     rst          synchronous reset, active-high
//     bus          systolic_seq_if.slave: in_* sample stream, out_* results
//     sys_in_data  registered drive to the array's in_data
//     sys_sum_out  array's sum_out
//     underrun     sticky: a zero bubble was injected in the current/last frame
//     frame_cnt    completed (handed-off) frames, wraps
//     busy         sequencer is not idle
// -----------------------------------------------------------------------------
module systolic_seq #(
    parameter int DATA_W  = 8,
    parameter int SUM_W   = 16,
    parameter int N_TAPS  = 8,
    parameter int LATENCY = 9,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    systolic_seq_if.slave      bus,
    output logic [DATA_W-1:0]  sys_in_data,
    input  logic [SUM_W-1:0]   sys_sum_out,
    output logic               underrun,
    output logic [CNT_W-1:0]   frame_cnt,
    output logic               busy
);

    // Counters must reach N_TAPS and LATENCY respectively without wrapping.
    localparam int SCNT_W = $clog2(N_TAPS + 1);
    localparam int FCNT_W = $clog2(LATENCY + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_sys_in;
    logic [SUM_W-1:0]  r_out_data;
    logic              r_out_valid;
    logic              r_underrun;
    logic [CNT_W-1:0]  r_frame_cnt;
    logic [SCNT_W-1:0] r_scnt;
    logic [FCNT_W-1:0] r_fcnt;

    logic w_in_ready;
    logic w_accept;
    logic w_last_slot;
    logic w_flush_end;

    // Ready depends on state only, so upstream never sees a valid->ready path.
    assign w_in_ready  = (r_state == S_IDLE) || (r_state == S_LOAD);
    assign w_accept    = bus.in_valid & w_in_ready;
    // r_scnt counts slots already written; this cycle writes slot r_scnt+1.
    assign w_last_slot = (r_scnt == SCNT_W'(N_TAPS - 1));
    assign w_flush_end = (r_fcnt == FCNT_W'(LATENCY - 1));

    // NOTE: state is updated with non-blocking assignments so every branch
    // reads the pre-edge values, exactly like the flops it describes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sys_in    <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_underrun  <= 1'b0;
            r_frame_cnt <= '0;
            r_scnt      <= '0;
            r_fcnt      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_sys_in <= '0;
                    if (w_accept) begin
                        r_sys_in   <= bus.in_data;
                        r_scnt     <= SCNT_W'(1);
                        r_fcnt     <= '0;
                        r_underrun <= 1'b0;
                        r_state    <= (N_TAPS == 1) ? S_FLUSH : S_LOAD;
                    end
                end

                S_LOAD: begin
                    // The array cannot stall: a missing sample still uses
                    // its slot, filled with zero, and is flagged.
                    r_scnt <= r_scnt + SCNT_W'(1);
                    if (w_accept) begin
                        r_sys_in <= bus.in_data;
                    end else begin
                        r_sys_in   <= '0;
                        r_underrun <= 1'b1;
                    end
                    if (w_last_slot) begin
                        r_fcnt  <= '0;
                        r_state <= S_FLUSH;
                    end
                end

                S_FLUSH: begin
                    // The capture edge lands LATENCY edges after the edge
                    // that registered the last sample.
                    r_sys_in <= '0;
                    r_fcnt   <= r_fcnt + FCNT_W'(1);
                    if (w_flush_end) begin
                        r_out_data  <= sys_sum_out;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end

                S_DONE: begin
                    r_sys_in <= '0;
                    if (r_out_valid && bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign sys_in_data   = r_sys_in;
    assign underrun      = r_underrun;
    assign frame_cnt     = r_frame_cnt;
    assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_systolic_seq.sv
// -----------------------------------------------------------------------------
// tb_systolic_seq
//   Bench for systolic_seq. A stub array sums the last N_TAPS values driven
//   on sys_in_data and delays that sum so the frame result is ready for the
//   capture edge. A frame-level reference model (list of slot values, flush
//   cycle count, result handshake) predicts every output and is compared on
//   each falling edge; directed scenarios pin literal results.
// -----------------------------------------------------------------------------
module tb_systolic_seq;

    localparam int DATA_W  = 8;
    localparam int SUM_W   = 16;
    localparam int N_TAPS  = 8;
    localparam int LATENCY = 9;
    localparam int CNT_W   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    systolic_seq_if #(.DATA_W(DATA_W), .SUM_W(SUM_W)) bus ();

    logic [DATA_W-1:0] sys_in_data;
    logic [SUM_W-1:0]  sys_sum_out;
    logic              underrun;
    logic [CNT_W-1:0]  frame_cnt;
    logic              busy;

    systolic_seq #(
        .DATA_W (DATA_W),
        .SUM_W  (SUM_W),
        .N_TAPS (N_TAPS),
        .LATENCY(LATENCY),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .sys_in_data(sys_in_data),
        .sys_sum_out(sys_sum_out),
        .underrun   (underrun),
        .frame_cnt  (frame_cnt),
        .busy       (busy)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- stub array: window sum of N_TAPS, delayed ------------
    logic [DATA_W-1:0] stub_hist [0:N_TAPS-2];
    logic [SUM_W-1:0]  stub_pipe [0:LATENCY-2];
    logic [SUM_W-1:0]  stub_win;

    initial begin
        for (int i = 0; i < N_TAPS - 1; i++) stub_hist[i] = '0;
        for (int i = 0; i < LATENCY - 1; i++) stub_pipe[i] = '0;
    end

    always_comb begin
        stub_win = SUM_W'(sys_in_data);
        for (int i = 0; i < N_TAPS - 1; i++) stub_win = stub_win + SUM_W'(stub_hist[i]);
    end

    always @(posedge clk) begin
        stub_hist[0] <= sys_in_data;
        for (int i = 1; i < N_TAPS - 1; i++) stub_hist[i] <= stub_hist[i-1];
        stub_pipe[0] <= stub_win;
        for (int i = 1; i < LATENCY - 1; i++) stub_pipe[i] <= stub_pipe[i-1];
    end

    assign sys_sum_out = stub_pipe[LATENCY-2];

    // ---------------- frame-level reference model --------------------------
    bit               m_en = 1'b0;
    bit               m_busy;        // a frame is in progress
    bit               m_have;        // result captured, awaiting handoff
    logic [7:0]       m_slots [$];   // slot values of the current frame
    int               m_wait;        // flush cycles elapsed after last slot
    logic [DATA_W-1:0] m_sys;
    logic [SUM_W-1:0] m_out_data;
    bit               m_out_valid;
    bit               m_underrun;
    logic [CNT_W-1:0] m_frame_cnt;

    function automatic logic [SUM_W-1:0] slot_sum();
        int s = 0;
        foreach (m_slots[i]) s += int'(m_slots[i]);
        return SUM_W'(s);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_en        = 1'b1;
            m_busy      = 1'b0;
            m_have      = 1'b0;
            m_slots.delete();
            m_wait      = 0;
            m_sys       = '0;
            m_out_data  = '0;
            m_out_valid = 1'b0;
            m_underrun  = 1'b0;
            m_frame_cnt = '0;
        end else if (!m_busy) begin
            m_sys = '0;
            if (bus.in_valid) begin
                m_sys = bus.in_data;
                m_slots.delete();
                m_slots.push_back(bus.in_data);
                m_underrun = 1'b0;
                m_busy     = 1'b1;
                m_wait     = 0;
            end
        end else if (m_slots.size() < N_TAPS) begin
            if (bus.in_valid) begin
                m_slots.push_back(bus.in_data);
                m_sys = bus.in_data;
            end else begin
                m_slots.push_back(8'h00);
                m_sys      = '0;
                m_underrun = 1'b1;
            end
            m_wait = 0;
        end else if (!m_have) begin
            m_sys  = '0;
            m_wait = m_wait + 1;
            if (m_wait == LATENCY) begin
                m_out_data  = slot_sum();
                m_out_valid = 1'b1;
                m_have      = 1'b1;
            end
        end else if (bus.out_ready) begin
            m_out_valid = 1'b0;
            m_frame_cnt = m_frame_cnt + 1'b1;
            m_busy      = 1'b0;
            m_have      = 1'b0;
            m_slots.delete();
        end
    end

    // Compare every cycle once the model has seen a reset.
    always @(negedge clk) begin
        if (m_en) begin
            check("cmp_sys_in_data", sys_in_data, m_sys);
            check("cmp_in_ready", bus.in_ready, (!m_busy) || (m_slots.size() < N_TAPS));
            check("cmp_out_valid", bus.out_valid, m_out_valid);
            check("cmp_out_data", bus.out_data, m_out_data);
            check("cmp_underrun", underrun, m_underrun);
            check("cmp_frame_cnt", frame_cnt, m_frame_cnt);
            check("cmp_busy", busy, m_busy);
        end
    end

    // ---------------- stimulus helpers -------------------------------------
    task automatic check_reset_state(input string tag);
        check({tag, "_sys_in_data"}, sys_in_data, 0);
        check({tag, "_out_data"}, bus.out_data, 0);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_underrun"}, underrun, 0);
        check({tag, "_frame_cnt"}, frame_cnt, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_in_ready"}, bus.in_ready, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_state("rst");
        rst = 1'b0;
    endtask

    task automatic send(input logic v, input logic [7:0] d);
        @(negedge clk);
        bus.in_valid = v;
        bus.in_data  = d;
    endtask

    task automatic wait_out_valid(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check("out_valid_timeout", ok, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------------------------------
    initial begin
        bit ok;
        int t_last;
        int t_prev;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        do_reset();

        // 1: continuous 0xFF stream
        bus.out_ready = 1'b1;
        for (int i = 0; i < N_TAPS; i++) send(1'b1, 8'hFF);
        @(negedge clk);
        t_last = cyc;
        bus.in_valid = 1'b0;
        check("t1_in_ready_dropped", bus.in_ready, 0);
        wait_out_valid(40, ok);
        check("t1_latency", cyc - t_last, LATENCY);
        check("t1_out_data", bus.out_data, 16'h07F8);
        check("t1_underrun", underrun, 0);
        @(negedge clk);
        check("t1_frame_cnt", frame_cnt, 1);
        check("t1_idle", busy, 0);

        // 2: bubble in the 4th slot
        send(1'b1, 8'h01);
        send(1'b1, 8'h02);
        send(1'b1, 8'h03);
        send(1'b0, 8'h00);
        send(1'b1, 8'h04);
        check("t2_bubble_slot_zero", sys_in_data, 0);
        check("t2_bubble_flag", underrun, 1);
        send(1'b1, 8'h05);
        send(1'b1, 8'h06);
        send(1'b1, 8'h07);
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_out_valid(40, ok);
        check("t2_out_data", bus.out_data, 16'h001C);
        check("t2_underrun", underrun, 1);
        @(negedge clk);
        check("t2_frame_cnt", frame_cnt, 2);
        check("t2_underrun_sticky", underrun, 1);

        // 3: back-pressure with a held in_valid
        bus.out_ready = 1'b0;
        for (int i = 1; i <= N_TAPS; i++) send(1'b1, 8'(i * 16));
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hAA;
        wait_out_valid(40, ok);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("t3_hold_valid", bus.out_valid, 1);
            check("t3_hold_data", bus.out_data, 16'h0240);
            check("t3_hold_in_ready", bus.in_ready, 0);
            check("t3_hold_sys_in", sys_in_data, 0);
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        @(negedge clk);
        check("t3_handshake_valid", bus.out_valid, 0);
        check("t3_frame_cnt", frame_cnt, 3);
        check("t3_idle", busy, 0);
        @(negedge clk);
        check("t3_frame_cnt_once", frame_cnt, 3);

        // 4: reset in the middle of LOAD
        for (int i = 0; i < 3; i++) send(1'b1, 8'h33);
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_reset_state("t4");
        rst = 1'b0;
        for (int i = 0; i < N_TAPS; i++) send(1'b1, 8'h10);
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_out_valid(40, ok);
        check("t4_out_data", bus.out_data, 16'h0080);
        @(negedge clk);
        check("t4_frame_cnt", frame_cnt, 1);

        // Randomized traffic, with rare resets; the model checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst           = ($urandom_range(0, 599) == 0);
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_data   = 8'($urandom);
            bus.out_ready = ($urandom_range(0, 2) != 0);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;

        // 5: 256 zero frames back to back -> counter wraps, 18-cycle period
        do_reset();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h00;
        t_prev = 0;
        for (int f = 0; f < 256; f++) begin
            wait_out_valid(40, ok);
            if (!ok) break;
            check("t5_out_data", bus.out_data, 0);
            if (f > 0) check("t5_period", cyc - t_prev, N_TAPS + LATENCY + 1);
            t_prev = cyc;
            if (f == 255) bus.in_valid = 1'b0;
        end
        @(negedge clk);
        check("t5_frame_cnt_wrap", frame_cnt, 0);
        check("t5_idle", busy, 0);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
